seg_scan: RTL and testbench

SEG_SCAN -- requirements
Module: seg_scan

---
 rtl/seg_scan.sv | 187 ++++++++++++++++++
 tb/tb_seg_scan.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: multiplexed driver for a six-digit, active-low, seven-segment display.
//
// Each digit gets a slot of SCAN_DIV cycles. The first BLANK_CYC cycles of every slot
// are dark (anti-ghosting) and the rest show the active digit. New content arrives
// through a pending register and is copied into the display register only at a frame
// boundary. A frame boundary is the wrap from digit 5 to digit 0, or the edge where
// scanning (re)starts. This keeps a frame from mixing old and new content.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   en       in   scan enable; low = display dark, counters held at slot 0
//   load     in   one-cycle request to capture data_in/dp_in/blank_in
//   data_in  in   [23:0] six hex nibbles, digit k = data_in[4k+3:4k]
//   dp_in    in   [5:0] decimal point per digit, 1 = lit
//   blank_in in   [5:0] per-digit blank, 1 = digit dark
//   seg      out  [7:0] active-low segments {dp,g,f,e,d,c,b,a}
//   sel      out  [5:0] active-low digit select
//   upd      out  one-cycle pulse when captured content becomes visible
//   frame    out  one-cycle pulse in the first cycle of every digit-0 slot
module seg_scan #(
   parameter int unsigned SCAN_DIV  = 50000,
   parameter int unsigned BLANK_CYC = 500
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        load,
   input  logic [23:0] data_in,
   input  logic [5:0]  dp_in,
   input  logic [5:0]  blank_in,
   output logic [7:0]  seg,
   output logic [5:0]  sel,
   output logic        upd,
   output logic        frame
);

   localparam int unsigned   CW      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CntLast = CW'(SCAN_DIV - 1);

   typedef enum logic {StBlank, StOn} state_e;

   function automatic logic [7:0] glyph(input logic [3:0] nib);
      case (nib)
         4'h0:    glyph = 8'hC0;
         4'h1:    glyph = 8'hF9;
         4'h2:    glyph = 8'hA4;
         4'h3:    glyph = 8'hB0;
         4'h4:    glyph = 8'h99;
         4'h5:    glyph = 8'h92;
         4'h6:    glyph = 8'h82;
         4'h7:    glyph = 8'hF8;
         4'h8:    glyph = 8'h80;
         4'h9:    glyph = 8'h90;
         4'hA:    glyph = 8'h88;
         4'hB:    glyph = 8'h83;
         4'hC:    glyph = 8'hC6;
         4'hD:    glyph = 8'hA1;
         4'hE:    glyph = 8'h86;
         default: glyph = 8'h8E;
      endcase
   endfunction

   // scan position; r_on is en as seen at the last edge
   logic          r_on;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_idx;
   logic          w_on_nxt;
   logic [CW-1:0] w_cnt_nxt;
   logic [2:0]    w_idx_nxt;
   logic          w_bound;
   state_e        w_state_nxt;

   // displayed and pending content
   logic [23:0] r_disp_data, w_disp_data_nxt, r_pend_data, w_pend_data_nxt;
   logic [5:0]  r_disp_dp, w_disp_dp_nxt, r_pend_dp, w_pend_dp_nxt;
   logic [5:0]  r_disp_blank, w_disp_blank_nxt, r_pend_blank, w_pend_blank_nxt;
   logic        r_pend_valid, w_pend_valid_nxt;

   // registered outputs
   logic [7:0] r_seg, w_seg_nxt;
   logic [5:0] r_sel, w_sel_nxt;
   logic       r_upd, w_upd_nxt;
   logic       r_frame;
   logic [3:0] w_nib;

   always_comb begin
      // scanning restarts when en is first seen high, or at the 5->0 wrap
      w_bound   = en && (!r_on || (r_cnt == CntLast && r_idx == 3'd5));
      w_on_nxt  = en;
      w_cnt_nxt = r_cnt;
      w_idx_nxt = r_idx;
      if (!en || w_bound) begin
         w_cnt_nxt = '0;
         w_idx_nxt = 3'd0;
      end else if (r_cnt == CntLast) begin
         w_cnt_nxt = '0;
         w_idx_nxt = r_idx + 3'd1;
      end else begin
         w_cnt_nxt = r_cnt + CW'(1);
      end
   end

   always_comb begin
      w_disp_data_nxt  = r_disp_data;
      w_disp_dp_nxt    = r_disp_dp;
      w_disp_blank_nxt = r_disp_blank;
      w_pend_data_nxt  = r_pend_data;
      w_pend_dp_nxt    = r_pend_dp;
      w_pend_blank_nxt = r_pend_blank;
      w_pend_valid_nxt = r_pend_valid;
      w_upd_nxt        = 1'b0;
      if (w_bound) begin
         // a load on the boundary edge bypasses pending and wins over it
         if (load) begin
            w_disp_data_nxt  = data_in;
            w_disp_dp_nxt    = dp_in;
            w_disp_blank_nxt = blank_in;
            w_upd_nxt        = 1'b1;
         end else if (r_pend_valid) begin
            w_disp_data_nxt  = r_pend_data;
            w_disp_dp_nxt    = r_pend_dp;
            w_disp_blank_nxt = r_pend_blank;
            w_upd_nxt        = 1'b1;
         end
         w_pend_valid_nxt = 1'b0;
      end else if (load) begin
         w_pend_data_nxt  = data_in;
         w_pend_dp_nxt    = dp_in;
         w_pend_blank_nxt = blank_in;
         w_pend_valid_nxt = 1'b1;
      end
   end

   // Outputs are computed from next-state values so the registered seg/sel line up
   // with the cnt/idx of the same cycle.
   always_comb begin
      w_state_nxt = (w_on_nxt && 32'(w_cnt_nxt) >= BLANK_CYC) ? StOn : StBlank;
      w_nib       = w_disp_data_nxt[{w_idx_nxt, 2'b00} +: 4];
      w_sel_nxt   = 6'h3F;
      w_seg_nxt   = 8'hFF;
      if (w_state_nxt == StOn && !w_disp_blank_nxt[w_idx_nxt]) begin
         w_sel_nxt = ~(6'd1 << w_idx_nxt);
         w_seg_nxt = glyph(w_nib) & {~w_disp_dp_nxt[w_idx_nxt], 7'h7F};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_on         <= 1'b0;
         r_cnt        <= '0;
         r_idx        <= 3'd0;
         r_disp_data  <= 24'h0;
         r_disp_dp    <= 6'h00;
         r_disp_blank <= 6'h3F;
         r_pend_data  <= 24'h0;
         r_pend_dp    <= 6'h00;
         r_pend_blank <= 6'h00;
         r_pend_valid <= 1'b0;
         r_seg        <= 8'hFF;
         r_sel        <= 6'h3F;
         r_upd        <= 1'b0;
         r_frame      <= 1'b0;
      end else begin
         r_on         <= w_on_nxt;
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_disp_data  <= w_disp_data_nxt;
         r_disp_dp    <= w_disp_dp_nxt;
         r_disp_blank <= w_disp_blank_nxt;
         r_pend_data  <= w_pend_data_nxt;
         r_pend_dp    <= w_pend_dp_nxt;
         r_pend_blank <= w_pend_blank_nxt;
         r_pend_valid <= w_pend_valid_nxt;
         r_seg        <= w_seg_nxt;
         r_sel        <= w_sel_nxt;
         r_upd        <= w_upd_nxt;
         r_frame      <= w_bound;
      end
   end

   assign seg   = r_seg;
   assign sel   = r_sel;
   assign upd   = r_upd;
   assign frame = r_frame;

endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: self-checking bench for seg_scan with SCAN_DIV=8, BLANK_CYC=2.
// A frame-position reference model predicts seg/sel/upd/frame every cycle; a vector
// table and hand-written sequences cover scan, tear-free update, last-wins,
// coincident load, dp/blank, enable and reset behaviour.
module tb_seg_scan;

   localparam int unsigned SD    = 8;
   localparam int unsigned BC    = 2;
   localparam int          FRAME = 6 * SD;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        en       = 1'b1;
   logic        load     = 1'b0;
   logic [23:0] data_in  = 24'h0;
   logic [5:0]  dp_in    = 6'h0;
   logic [5:0]  blank_in = 6'h0;
   logic [7:0]  seg;
   logic [5:0]  sel;
   logic        upd;
   logic        frame;

   always #5 clk = ~clk;

   seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .load     (load),
      .data_in  (data_in),
      .dp_in    (dp_in),
      .blank_in (blank_in),
      .seg      (seg),
      .sel      (sel),
      .upd      (upd),
      .frame    (frame)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model: position within the frame ----------------
   logic [7:0]  glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   bit          m_on;
   int          m_pos;
   logic [23:0] m_data, m_pdata;
   logic [5:0]  m_dp, m_blank, m_pdp, m_pblank;
   bit          m_pv, m_upd, m_frame;

   task automatic model_reset();
      m_on = 0; m_pos = 0; m_data = 24'h0; m_dp = 6'h0; m_blank = 6'h3F;
      m_pv = 0; m_pdata = 24'h0; m_pdp = 6'h0; m_pblank = 6'h0; m_upd = 0; m_frame = 0;
   endtask

   task automatic model_step();
      bit bound;
      bound   = en && (!m_on || m_pos == FRAME - 1);
      m_upd   = 0;
      m_frame = bound;
      if (!en) begin
         m_on = 0; m_pos = 0;
      end else if (!m_on) begin
         m_on = 1; m_pos = 0;
      end else begin
         m_pos = (m_pos + 1) % FRAME;
      end
      if (bound) begin
         if (load) begin
            m_data = data_in; m_dp = dp_in; m_blank = blank_in; m_upd = 1;
         end else if (m_pv) begin
            m_data = m_pdata; m_dp = m_pdp; m_blank = m_pblank; m_upd = 1;
         end
         m_pv = 0;
      end else if (load) begin
         m_pdata = data_in; m_pdp = dp_in; m_pblank = blank_in; m_pv = 1;
      end
   endtask

   task automatic model_outputs(output logic [5:0] s, output logic [7:0] g);
      int         k;
      int         off;
      logic [3:0] nib;
      k   = m_pos / SD;
      off = m_pos % SD;
      s   = 6'h3F;
      g   = 8'hFF;
      if (m_on && off >= BC && !m_blank[k]) begin
         s   = ~(6'd1 << k);
         nib = 4'(m_data >> (4 * k));
         g   = glyph_tab[nib];
         if (m_dp[k]) g[7] = 1'b0;
      end
   endtask

   // one clock: inputs already driven; DUT and model advance; compare at negedge
   task automatic step();
      logic [5:0] es;
      logic [7:0] eg;
      @(posedge clk);
      model_step();
      @(negedge clk);
      model_outputs(es, eg);
      check("sel", sel, es);
      check("seg", seg, eg);
      check("upd", upd, m_upd);
      check("frame", frame, m_frame);
   endtask

   task automatic do_load(input logic [23:0] d, input logic [5:0] dp, input logic [5:0] bl);
      data_in = d; dp_in = dp; blank_in = bl; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic run_to(input int pos);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (m_on && m_pos == pos) begin
            ok = 1;
            break;
         end
         step();
      end
      if (!ok) check("run_to_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_frame();
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         step();
         if (m_frame) begin
            ok = 1;
            break;
         end
      end
      if (!ok) check("wait_frame_timeout", 32'd0, 32'd1);
   endtask

   typedef struct {
      logic [23:0] data;
      logic [5:0]  dp;
      logic [5:0]  blank;
      int          digit;
      logic [5:0]  exp_sel;
      logic [7:0]  exp_seg;
   } vec_t;

   vec_t vecs [10];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int n, nlit, nfr, nupd, nbad;

      vecs[0] = '{24'h543210, 6'h00, 6'h00, 0, 6'h3E, 8'hC0};
      vecs[1] = '{24'h543210, 6'h00, 6'h00, 1, 6'h3D, 8'hF9};
      vecs[2] = '{24'h543210, 6'h00, 6'h00, 2, 6'h3B, 8'hA4};
      vecs[3] = '{24'h543210, 6'h00, 6'h00, 3, 6'h37, 8'hB0};
      vecs[4] = '{24'h543210, 6'h00, 6'h00, 4, 6'h2F, 8'h99};
      vecs[5] = '{24'h543210, 6'h00, 6'h00, 5, 6'h1F, 8'h92};
      vecs[6] = '{24'h000000, 6'h01, 6'h20, 0, 6'h3E, 8'h40};
      vecs[7] = '{24'h000000, 6'h01, 6'h20, 5, 6'h3F, 8'hFF};
      vecs[8] = '{24'hABCDEF, 6'h00, 6'h00, 1, 6'h3D, 8'h86};
      vecs[9] = '{24'h888888, 6'h3F, 6'h00, 4, 6'h2F, 8'h00};

      // reset state and a dark first frame
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("rst_sel", sel, 6'h3F);
      check("rst_seg", seg, 8'hFF);
      check("rst_upd", upd, 1'b0);
      check("rst_frame", frame, 1'b0);
      rst_n = 1'b1;
      nlit = 0; nfr = 0;
      for (int i = 0; i < FRAME; i++) begin
         step();
         if (sel != 6'h3F) nlit++;
         if (frame) nfr++;
      end
      check("dark_frame_lit", nlit, 0);
      check("dark_frame_frames", nfr, 1);

      // table: load, wait for the boundary, inspect one digit mid-slot
      foreach (vecs[v]) begin
         do_load(vecs[v].data, vecs[v].dp, vecs[v].blank);
         wait_frame();
         run_to(vecs[v].digit * SD + 4);
         check("vec_sel", sel, vecs[v].exp_sel);
         check("vec_seg", seg, vecs[v].exp_seg);
      end

      // digit 5 blanked: dark through all its ON cycles
      do_load(24'h0, 6'h01, 6'h20);
      wait_frame();
      run_to(5 * SD);
      nlit = 0;
      for (int i = 0; i < SD; i++) begin
         step();
         if (m_pos / SD == 5 && sel != 6'h3F) nlit++;
      end
      check("blank_digit5_lit", nlit, 0);

      // frame period
      wait_frame();
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         n++;
         if (frame) break;
      end
      check("frame_period", n, FRAME);

      // asynchronous reset mid-slot
      do_load(24'h888888, 6'h3F, 6'h00);
      wait_frame();
      run_to(2 * SD + 4);
      check("pre_reset_sel", sel, 6'h3B);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sel", sel, 6'h3F);
      check("async_rst_seg", seg, 8'hFF);
      check("async_rst_upd", upd, 1'b0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step();
      check("post_rst_frame", frame, 1'b1);

      // tear-free update
      do_load(24'h543210, 6'h00, 6'h00);
      wait_frame();
      run_to(3 * SD + 3);
      do_load(24'hFFFFFF, 6'h00, 6'h00);
      run_to(4 * SD + 4);
      check("tear_old_d4", seg, 8'h99);
      run_to(5 * SD + 4);
      check("tear_old_d5", seg, 8'h92);
      wait_frame();
      check("tear_upd", upd, 1'b1);
      nupd = 0; nbad = 0;
      for (int i = 1; i < FRAME; i++) begin
         step();
         nupd += int'(upd);
         if (m_pos % SD >= BC && seg != 8'h8E) nbad++;
      end
      check("tear_upd_extra", nupd, 0);
      check("tear_new_glyph_bad", nbad, 0);

      // last load wins, no mid-frame change
      run_to(10);
      do_load(24'h111111, 6'h00, 6'h00);
      run_to(30);
      do_load(24'h222222, 6'h00, 6'h00);
      run_to(36);
      check("no_mid_update", seg, 8'h8E);
      wait_frame();
      run_to(4);
      check("last_wins", seg, 8'hA4);

      // load coincident with the boundary edge
      run_to(FRAME - 1);
      do_load(24'h333333, 6'h00, 6'h00);
      check("coincide_frame", frame, 1'b1);
      check("coincide_upd", upd, 1'b1);
      run_to(2);
      check("coincide_seg", seg, 8'hB0);

      // enable low mid-frame, load while dark, restart
      run_to(20);
      en = 1'b0;
      step();
      check("en_off_sel", sel, 6'h3F);
      do_load(24'h444444, 6'h00, 6'h00);
      nlit = 0; nfr = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (sel != 6'h3F || seg != 8'hFF) nlit++;
         if (frame) nfr++;
      end
      check("en_off_lit", nlit, 0);
      check("en_off_frames", nfr, 0);
      en = 1'b1;
      step();
      check("en_on_frame", frame, 1'b1);
      check("en_on_upd", upd, 1'b1);
      run_to(2);
      check("en_on_seg", seg, 8'h99);
      check("en_on_sel", sel, 6'h3E);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(0, 99) < 97);
         load     = ($urandom_range(0, 19) == 0);
         data_in  = 24'($urandom);
         dp_in    = 6'($urandom);
         blank_in = 6'($urandom) & 6'($urandom);
         step();
      end
      load = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
